ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_pkg.sv | 114 +++++++++++
 rtl/alu.sv | 48 ++++
 rtl/ex_stage.sv | 119 +++++++++++
 tb/tb_ex_stage.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types for the execute stage: ALU opcodes, branch conditions, flag word,
// packed control-field layouts and the ID/EX register image.
package ex_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_NAND = 4'h2,
    OP_XOR  = 4'h3,
    OP_SRA  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SLL  = 4'h7,
    OP_LHB  = 4'hA,
    OP_LLB  = 4'hB
  } alu_op_e;

  typedef enum logic [2:0] {
    BC_NE = 3'd0,
    BC_EQ = 3'd1,
    BC_GT = 3'd2,
    BC_LT = 3'd3,
    BC_GE = 3'd4,
    BC_LE = 3'd5,
    BC_OV = 3'd6,
    BC_AL = 3'd7
  } bcond_e;

  typedef enum logic [1:0] {
    FU_NONE,
    FU_Z,
    FU_ZVN
  } flag_upd_e;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  typedef struct packed {
    logic       branch;
    logic       instr15;
    logic       sp_addr;
    logic       pc_to_mem;
    logic [1:0] alu_src;
    alu_op_e    alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_write;
    logic [3:0] dst;
    logic [3:0] r1_addr;
    logic [3:0] r0_addr;
  } fwd_ctrl_t;

  // valid distinguishes a real instruction from a bubble (both may carry ALUOp 0).
  typedef struct packed {
    logic        valid;
    logic [15:0] pc_inc;
    logic [15:0] pc_branch;
    logic [15:0] r0_data;
    logic [15:0] r1_data;
    logic [15:0] imm;
    logic [7:0]  offset;
    bcond_e      bcond;
    ex_ctrl_t    ex;
    logic [1:0]  m;
    logic [6:0]  wb;
    fwd_ctrl_t   fwd;
  } idex_t;

  localparam logic [1:0] SRC_R1  = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] SRC_OFF = 2'b10;

  function automatic logic cond_met(input bcond_e bc, input flags_t f);
    case (bc)
      BC_NE:   return !f.z;
      BC_EQ:   return f.z;
      BC_GT:   return !f.z && !f.n;
      BC_LT:   return f.n;
      BC_GE:   return f.z || !f.n;
      BC_LE:   return f.n || f.z;
      BC_OV:   return f.v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic flag_upd_e flag_class(input alu_op_e op);
    case (op)
      OP_ADD, OP_SUB:                          return FU_ZVN;
      OP_NAND, OP_XOR, OP_SRA, OP_SRL, OP_SLL: return FU_Z;
      default:                                 return FU_NONE;
    endcase
  endfunction

  // Register 0 is hard-wired, so it is never a forwarding target.
  function automatic logic [15:0] fwd_pick(
    input logic [3:0]  addr,
    input logic [15:0] rf_data,
    input logic        xm_we,
    input logic [3:0]  xm_addr,
    input logic [15:0] xm_data,
    input logic        mw_we,
    input logic [3:0]  mw_addr,
    input logic [15:0] mw_data
  );
    if (xm_we && addr != 4'd0 && xm_addr == addr) return xm_data;
    if (mw_we && addr != 4'd0 && mw_addr == addr) return mw_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU returning the result and the {Z,V,N} flags it would produce.
// With EX_SAT_EN defined, ADD/SUB clamp to 16'h7FFF/16'h8000 on signed overflow.
module alu
  import ex_pkg::*;
(
  input  alu_op_e     op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output flags_t      flags
);

  logic [15:0] sum;
  logic [15:0] diff;
  logic        ovf_add;
  logic        ovf_sub;
  logic        ovf;

  assign sum     = a + b;
  assign diff    = a - b;
  assign ovf_add = (a[15] == b[15]) && (sum[15] != a[15]);
  assign ovf_sub = (a[15] != b[15]) && (diff[15] != a[15]);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD:  begin result = sum;  ovf = ovf_add; end
      OP_SUB:  begin result = diff; ovf = ovf_sub; end
      OP_NAND: result = ~(a & b);
      OP_XOR:  result = a ^ b;
      OP_SRA:  result = $signed(a) >>> b[3:0];
      OP_SRL:  result = a >> b[3:0];
      OP_SLL:  result = a << b[3:0];
      OP_LHB:  result = {b[7:0], a[7:0]};
      OP_LLB:  result = {a[15:8], b[7:0]};
      default: result = '0;
    endcase
`ifdef EX_SAT_EN
    // Overflow direction follows the sign of A for both ADD and SUB.
    if (ovf) result = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    flags.z = (result == 16'h0000);
    flags.v = ovf;
    flags.n = result[15];
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, flags register and branch resolution.
// Optional build macro EX_SAT_EN selects saturating ADD/SUB inside the ALU.
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] PC_inc_in,
  input  logic [15:0] PCbranch_in,
  input  logic [15:0] r0data_in,
  input  logic [15:0] r1data_in,
  input  logic [15:0] imm_in,
  input  logic [15:0] offset_in,
  input  logic [2:0]  bcond_in,
  input  logic [9:0]  EX_in,
  input  logic [1:0]  M_in,
  input  logic [6:0]  WB_in,
  input  logic [13:0] FWD_in,
  input  logic        xm_we,
  input  logic [3:0]  xm_addr,
  input  logic [15:0] xm_data,
  input  logic        mw_we,
  input  logic [3:0]  mw_addr,
  input  logic [15:0] mw_data,
  output logic [15:0] alu_out,
  output logic [15:0] mem_addr,
  output logic [15:0] store_data,
  output logic        branch_taken,
  output logic [15:0] branch_target,
  output logic [1:0]  M_out,
  output logic [6:0]  WB_out
);

  idex_t       idex_reg;
  idex_t       idex_next;
  flags_t      flags_reg;
  flags_t      alu_flags;
  logic [15:0] op_a;
  logic [15:0] op_r1;
  logic [15:0] op_b;
  logic [15:0] alu_result;
  logic        unused_bits;

  always_comb begin
    idex_next           = '0;
    idex_next.valid     = 1'b1;
    idex_next.pc_inc    = PC_inc_in;
    idex_next.pc_branch = PCbranch_in;
    idex_next.r0_data   = r0data_in;
    idex_next.r1_data   = r1data_in;
    idex_next.imm       = imm_in;
    idex_next.offset    = offset_in[7:0];
    idex_next.bcond     = bcond_e'(bcond_in);
    idex_next.ex        = ex_ctrl_t'(EX_in);
    idex_next.m         = M_in;
    idex_next.wb        = WB_in;
    idex_next.fwd       = fwd_ctrl_t'(FWD_in);
  end

  // A bubble clears the whole register so every output reads zero while it passes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_reg <= '0;
    end else if (flush) begin
      idex_reg <= '0;
    end else if (!stall) begin
      idex_reg <= idex_next;
    end
  end

  assign op_a  = fwd_pick(idex_reg.fwd.r0_addr, idex_reg.r0_data,
                          xm_we, xm_addr, xm_data, mw_we, mw_addr, mw_data);
  assign op_r1 = fwd_pick(idex_reg.fwd.r1_addr, idex_reg.r1_data,
                          xm_we, xm_addr, xm_data, mw_we, mw_addr, mw_data);

  always_comb begin
    case (idex_reg.ex.alu_src)
      SRC_R1:  op_b = op_r1;
      SRC_IMM: op_b = idex_reg.imm;
      SRC_OFF: op_b = {8'h00, idex_reg.offset};
      default: op_b = 16'h0002;
    endcase
  end

  alu u_alu (
    .op     (idex_reg.ex.alu_op),
    .a      (op_a),
    .b      (op_b),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_reg <= '0;
    end else if (!stall && idex_reg.valid) begin
      case (flag_class(idex_reg.ex.alu_op))
        FU_ZVN:  flags_reg   <= alu_flags;
        FU_Z:    flags_reg.z <= alu_flags.z;
        default: ;
      endcase
    end
  end

  assign alu_out       = alu_result;
  assign mem_addr      = idex_reg.ex.sp_addr ? op_a : alu_result;
  assign store_data    = idex_reg.ex.pc_to_mem ? idex_reg.pc_inc : op_r1;
  // Branches resolve on the flags left by the previous instruction, not the in-flight result.
  assign branch_taken  = idex_reg.ex.branch && cond_met(idex_reg.bcond, flags_reg) && !stall;
  assign branch_target = idex_reg.pc_branch;
  assign M_out         = idex_reg.m;
  assign WB_out        = idex_reg.wb;

  assign unused_bits = ^{idex_reg.ex.instr15, idex_reg.fwd.mem_to_reg, idex_reg.fwd.reg_write,
                         idex_reg.fwd.dst, offset_in[15:8]};

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a reference model predicts each cycle's outputs,
// directed vectors cover forwarding, overflow, branches, CALL, stall, flush and reset.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [15:0] PC_inc_in, PCbranch_in, r0data_in, r1data_in, imm_in, offset_in;
  logic [2:0]  bcond_in;
  logic [9:0]  EX_in;
  logic [1:0]  M_in;
  logic [6:0]  WB_in;
  logic [13:0] FWD_in;
  logic        xm_we, mw_we;
  logic [3:0]  xm_addr, mw_addr;
  logic [15:0] xm_data, mw_data;
  logic [15:0] alu_out, mem_addr, store_data, branch_target;
  logic        branch_taken;
  logic [1:0]  M_out;
  logic [6:0]  WB_out;

  typedef struct packed {
    logic [15:0] pc_inc, pcb, r0, r1, imm, off;
    logic [2:0]  bc;
    logic [9:0]  ex;
    logic [1:0]  m;
    logic [6:0]  wb;
    logic [13:0] fwd;
  } idv_t;

  typedef struct packed {
    logic xw; logic [3:0] xa; logic [15:0] xd;
    logic mw; logic [3:0] ma; logic [15:0] md;
  } fw_t;

  typedef struct packed {
    logic [15:0] alu, maddr, sdata, btgt;
    logic        bt;
    logic [1:0]  m;
    logic [6:0]  wb;
  } exp_t;

`ifdef EX_SAT_EN
  localparam logic [15:0] ADD_OVF_EXP = 16'h7FFF;
  localparam logic        ADD_OVF_N   = 1'b0;
`else
  localparam logic [15:0] ADD_OVF_EXP = 16'h8000;
  localparam logic        ADD_OVF_N   = 1'b1;
`endif
  localparam fw_t FW_NONE = '0;

  exp_t       sbq[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         n_step = 0;
  idv_t       st;
  logic       st_valid;
  logic [2:0] mf;
  fw_t        cur_fw;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .PC_inc_in(PC_inc_in), .PCbranch_in(PCbranch_in),
    .r0data_in(r0data_in), .r1data_in(r1data_in),
    .imm_in(imm_in), .offset_in(offset_in), .bcond_in(bcond_in),
    .EX_in(EX_in), .M_in(M_in), .WB_in(WB_in), .FWD_in(FWD_in),
    .xm_we(xm_we), .xm_addr(xm_addr), .xm_data(xm_data),
    .mw_we(mw_we), .mw_addr(mw_addr), .mw_data(mw_data),
    .alu_out(alu_out), .mem_addr(mem_addr), .store_data(store_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .M_out(M_out), .WB_out(WB_out)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (step %0d)", tag, got, want, n_step);
    end
  endtask

  function automatic idv_t mk(input logic [9:0] ex, input logic [2:0] bc,
                              input logic [15:0] r0, input logic [15:0] r1,
                              input logic [15:0] imm, input logic [3:0] a0, input logic [3:0] a1);
    idv_t v;
    v.pc_inc = 16'h0042; v.pcb = 16'h1234; v.off = 16'hFF85;
    v.r0 = r0; v.r1 = r1; v.imm = imm; v.bc = bc; v.ex = ex;
    v.m = 2'b10; v.wb = 7'b0101_100; v.fwd = {2'b01, 4'h5, a1, a0};
    return v;
  endfunction

  function automatic fw_t fwv(input logic xw, input logic [3:0] xa, input logic [15:0] xd,
                              input logic mw, input logic [3:0] ma, input logic [15:0] md);
    fw_t f;
    f.xw = xw; f.xa = xa; f.xd = xd; f.mw = mw; f.ma = ma; f.md = md;
    return f;
  endfunction

  function automatic logic [15:0] pick(input logic [3:0] a, input logic [15:0] rf, input fw_t f);
    if (f.xw && a != 4'd0 && f.xa == a) return f.xd;
    if (f.mw && a != 4'd0 && f.ma == a) return f.md;
    return rf;
  endfunction

  function automatic logic m_cond(input logic [2:0] bc, input logic [2:0] fl);
    logic z, v, n;
    z = fl[2]; v = fl[1]; n = fl[0];
    case (bc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic m_eval(input idv_t s, input fw_t f, output logic [15:0] a, output logic [15:0] r1f,
                        output logic [15:0] res, output logic vf, output int cls);
    logic [15:0] b;
    int sum;
    a = pick(s.fwd[3:0], s.r0, f);
    r1f = pick(s.fwd[7:4], s.r1, f);
    case (s.ex[5:4])
      2'b00:   b = r1f;
      2'b01:   b = s.imm;
      2'b10:   b = {8'h00, s.off[7:0]};
      default: b = 16'h0002;
    endcase
    res = 16'h0000; vf = 1'b0; cls = 0; sum = 0;
    case (s.ex[3:0])
      4'h0, 4'h1: begin
        sum = (s.ex[3:0] == 4'h0) ? int'($signed(a)) + int'($signed(b))
                                   : int'($signed(a)) - int'($signed(b));
        vf  = (sum > 32767) || (sum < -32768);
        res = sum[15:0];
`ifdef EX_SAT_EN
        if (vf) res = (sum > 0) ? 16'h7FFF : 16'h8000;
`endif
        cls = 2;
      end
      4'h2: begin res = ~(a & b); cls = 1; end
      4'h3: begin res = a ^ b; cls = 1; end
      4'h5: begin res = 16'($signed(a) >>> b[3:0]); cls = 1; end
      4'h6: begin res = a >> b[3:0]; cls = 1; end
      4'h7: begin res = a << b[3:0]; cls = 1; end
      4'hA: res = {b[7:0], a[7:0]};
      4'hB: res = {a[15:8], b[7:0]};
      default: res = 16'h0000;
    endcase
  endtask

  // One clock edge of the reference: flags from the outgoing instruction, then the register load.
  task automatic model_step(input idv_t in, input bit fl, input bit se, input fw_t fw, input bit so,
                            output exp_t e);
    logic [15:0] a, r1f, res;
    logic vf;
    int cls;
    if (!se && st_valid) begin
      m_eval(st, cur_fw, a, r1f, res, vf, cls);
      if (cls == 2) mf = {res == 16'h0000, vf, res[15]};
      else if (cls == 1) mf[2] = (res == 16'h0000);
    end
    if (fl) begin
      st = '0; st_valid = 1'b0;
    end else if (!se) begin
      st = in; st_valid = 1'b1;
    end
    cur_fw = fw;
    m_eval(st, fw, a, r1f, res, vf, cls);
    e.alu   = res;
    e.maddr = st.ex[7] ? a : res;
    e.sdata = st.ex[6] ? st.pc_inc : r1f;
    e.bt    = st.ex[9] && m_cond(st.bc, mf) && !so;
    e.btgt  = st.pcb;
    e.m     = st.m;
    e.wb    = st.wb;
  endtask

  task automatic step(input idv_t v, input bit fl, input bit se, input fw_t fw, input bit so);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    PC_inc_in = v.pc_inc; PCbranch_in = v.pcb; r0data_in = v.r0; r1data_in = v.r1;
    imm_in = v.imm; offset_in = v.off; bcond_in = v.bc; EX_in = v.ex;
    M_in = v.m; WB_in = v.wb; FWD_in = v.fwd;
    flush = fl; stall = se;
    model_step(v, fl, se, fw, so, e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    xm_we = fw.xw; xm_addr = fw.xa; xm_data = fw.xd;
    mw_we = fw.mw; mw_addr = fw.ma; mw_data = fw.md;
    stall = so;
    #1;
    e = sbq.pop_front();
    n_step++;
    $display("step %0d ex=%h fl=%0d st=%0d/%0d alu=%h maddr=%h sdata=%h bt=%0d tgt=%h",
             n_step, v.ex, fl, se, so, alu_out, mem_addr, store_data, branch_taken, branch_target);
    chk("alu_out", alu_out, e.alu);
    chk("mem_addr", mem_addr, e.maddr);
    chk("store_data", store_data, e.sdata);
    chk("branch_taken", 16'(branch_taken), 16'(e.bt));
    chk("branch_target", branch_target, e.btgt);
    chk("M_out", 16'(M_out), 16'(e.m));
    chk("WB_out", 16'(WB_out), 16'(e.wb));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_alu"}, alu_out, 16'h0000);
    chk({tag, "_maddr"}, mem_addr, 16'h0000);
    chk({tag, "_sdata"}, store_data, 16'h0000);
    chk({tag, "_bt"}, 16'(branch_taken), 16'h0000);
    chk({tag, "_tgt"}, branch_target, 16'h0000);
    chk({tag, "_m"}, 16'(M_out), 16'h0000);
    chk({tag, "_wb"}, 16'(WB_out), 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    st = '0; st_valid = 1'b0; mf = 3'b000;
    $display("reset asserted mid-stream");
    chk_zero("rst_async");
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
  endtask

  initial begin
    idv_t v;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    PC_inc_in = '0; PCbranch_in = '0; r0data_in = '0; r1data_in = '0; imm_in = '0; offset_in = '0;
    bcond_in = '0; EX_in = '0; M_in = '0; WB_in = '0; FWD_in = '0;
    xm_we = 1'b0; xm_addr = '0; xm_data = '0; mw_we = 1'b0; mw_addr = '0; mw_data = '0;
    st = '0; st_valid = 1'b0; mf = 3'b000; cur_fw = '0;

    repeat (2) @(posedge clk);
    #1;
    $display("initial reset");
    chk_zero("reset");

    // Signed overflow on ADD, then branches that read V and N from the flags register.
    step(mk(10'h010, 3'd0, 16'h7FFF, 16'h0000, 16'h0001, 4'd3, 4'd4), 0, 0, FW_NONE, 0);
    chk("ovf_alu", alu_out, ADD_OVF_EXP);
    step(mk(10'h304, 3'd6, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0), 0, 0, FW_NONE, 0);
    chk("ovf_bt", 16'(branch_taken), 16'h0001);
    chk("ovf_tgt", branch_target, 16'h1234);
    step(mk(10'h304, 3'd3, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0), 0, 0, FW_NONE, 0);
    chk("ovf_n_bt", 16'(branch_taken), 16'(ADD_OVF_N));

    // SUB r1=r2-r3, then ADD r4=r1+r1 with r1 forwarded from EX/MEM.
    step(mk(10'h001, 3'd0, 16'h0009, 16'h0004, 16'h0000, 4'd2, 4'd3), 0, 0, FW_NONE, 0);
    chk("sub_alu", alu_out, 16'h0005);
    step(mk(10'h000, 3'd0, 16'h0055, 16'h0055, 16'h0000, 4'd1, 4'd1), 0, 0,
         fwv(1, 4'd1, 16'd5, 0, 4'd0, 16'd0), 0);
    chk("fwd_xm_alu", alu_out, 16'd10);

    // Both sources hit r2: EX/MEM wins; address 0 never forwards; MEM/WB alone.
    step(mk(10'h010, 3'd0, 16'h0003, 16'h0000, 16'h0000, 4'd2, 4'd0), 0, 0,
         fwv(1, 4'd2, 16'd7, 1, 4'd2, 16'd9), 0);
    chk("fwd_prio_alu", alu_out, 16'd7);
    step(mk(10'h010, 3'd0, 16'h0003, 16'h0000, 16'h0000, 4'd0, 4'd0), 0, 0,
         fwv(1, 4'd0, 16'd7, 1, 4'd0, 16'd9), 0);
    chk("fwd_r0_alu", alu_out, 16'd3);
    step(mk(10'h010, 3'd0, 16'h0003, 16'h0000, 16'h0000, 4'd2, 4'd0), 0, 0,
         fwv(0, 4'd2, 16'd7, 1, 4'd2, 16'd9), 0);
    chk("fwd_mw_alu", alu_out, 16'd9);

    // SUB 3-3 sets Z; EQ taken, NE not taken.
    step(mk(10'h011, 3'd0, 16'h0003, 16'h0000, 16'h0003, 4'd2, 4'd0), 0, 0, FW_NONE, 0);
    step(mk(10'h304, 3'd1, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0), 0, 0, FW_NONE, 0);
    chk("beq_bt", 16'(branch_taken), 16'h0001);
    chk("beq_tgt", branch_target, 16'h1234);
    step(mk(10'h304, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0), 0, 0, FW_NONE, 0);
    chk("bne_bt", 16'(branch_taken), 16'h0000);

    // CALL: push return PC at SP, SP decremented by 2.
    step(mk(10'h0F1, 3'd0, 16'h0100, 16'h7777, 16'h0000, 4'd6, 4'd7), 0, 0, FW_NONE, 0);
    chk("call_maddr", mem_addr, 16'h0100);
    chk("call_alu", alu_out, 16'h00FE);
    chk("call_sdata", store_data, 16'h0042);

    // Branch caught by a stall: suppressed while stalled, one taken cycle after release.
    v = mk(10'h000, 3'd0, 16'h0011, 16'h0022, 16'h0000, 4'd3, 4'd4);
    step(mk(10'h304, 3'd7, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0), 0, 0, FW_NONE, 1);
    chk("stall_bt0", 16'(branch_taken), 16'h0000);
    step(v, 0, 1, FW_NONE, 1);
    chk("stall_bt1", 16'(branch_taken), 16'h0000);
    step(v, 0, 1, FW_NONE, 0);
    chk("release_bt", 16'(branch_taken), 16'h0001);
    step(v, 0, 0, FW_NONE, 0);
    chk("after_bt", 16'(branch_taken), 16'h0000);

    // Reset in the middle of traffic, then a flush that overrides stall.
    do_reset();
    step(mk(10'h304, 3'd0, 16'h0005, 16'h0006, 16'h0007, 4'd1, 4'd2), 1, 1,
         fwv(1, 4'd1, 16'hAAAA, 0, 4'd0, 16'd0), 0);
    chk("flush_bt", 16'(branch_taken), 16'h0000);
    chk("flush_alu", alu_out, 16'h0000);
    step(mk(10'h304, 3'd1, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0), 0, 0, FW_NONE, 0);
    chk("flags0_beq", 16'(branch_taken), 16'h0000);
    step(mk(10'h304, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0), 0, 0, FW_NONE, 0);
    chk("flags0_bne", 16'(branch_taken), 16'h0001);

    for (int i = 0; i < 40; i++) begin
      idv_t r;
      fw_t  f;
      r.pc_inc = 16'($urandom); r.pcb = 16'($urandom);
      r.r0 = 16'($urandom); r.r1 = 16'($urandom);
      r.imm = 16'($urandom); r.off = 16'($urandom);
      r.bc = 3'($urandom); r.ex = 10'($urandom);
      r.m = 2'($urandom); r.wb = 7'($urandom);
      r.fwd = 14'($urandom);
      r.fwd[3:0] = 4'($urandom_range(0, 3));
      r.fwd[7:4] = 4'($urandom_range(0, 3));
      f = fwv(1'($urandom), 4'($urandom_range(0, 3)), 16'($urandom),
              1'($urandom), 4'($urandom_range(0, 3)), 16'($urandom));
      step(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0), f, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
